// File: rtl/mm_stage_pkg.sv
// Shared types for the memory-access stage.
// Word/register typedefs, MEM FSM states, writeback source select.
package mm_stage_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mmstate_t;

    typedef enum logic [1:0] {
        MTR_ALU = 2'd0,
        MTR_MEM = 2'd1,
        MTR_NPC = 2'd2
    } memtoreg_t;

    // Non-load writeback source; 3 is unused and falls back to ALUOut.
    function automatic word_t wsel(
        input memtoreg_t m,
        input word_t     alu,
        input word_t     npc
    );
        return (m == MTR_NPC) ? npc : alu;
    endfunction

endpackage

// File: rtl/mm_stage_if.sv
// Data-cache request/response bundle plus coherence invalidate.
// master: stage side (drives REN/WEN/addr/store); slave: cache side.
interface mm_stage_if;
    import mm_stage_pkg::*;

    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  dhit;
    word_t dmemload;
    logic  ccinv;
    word_t ccsnoopaddr;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload, ccinv, ccsnoopaddr
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload, ccinv, ccsnoopaddr
    );

endinterface

// File: rtl/mm_stage_link_reg.sv
// LL/SC link register: set by LL, killed by SC, store or snoop.
// Ports: CLK, RST, set/clr/st/snoop strobes, addresses, match out.
module mm_stage_link_reg
    import mm_stage_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  set,
    input  logic  clr,
    input  logic  st,
    input  logic  snoop,
    input  word_t addr,
    input  word_t snoop_addr,
    input  word_t cmp_addr,
    output logic  match
);

    word_t link_addr;
    logic  link_valid;
    word_t nxt_addr;
    logic  kill;

    // A snoop that lands with an LL must be checked against the
    // address being linked, so the invalidate beats the set.
    assign nxt_addr = set ? addr : link_addr;
    assign kill = clr
                | (st & (addr == link_addr))
                | (snoop & (snoop_addr == nxt_addr));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            if (set)
                link_addr <= addr;
            if (kill)
                link_valid <= 1'b0;
            else if (set)
                link_valid <= 1'b1;
        end
    end

    assign match = link_valid & (link_addr == cmp_addr);

endmodule

// File: rtl/mm_stage.sv
// Memory stage: dcache access FSM, MEM/WB register, LL/SC link.
// Ports: EX/MEM fields in, dcache bundle (dc), WB fields and stall out.
module mm_stage
    import mm_stage_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  regbits_t   rd,
    input  logic       RegWEN,
    input  logic [1:0] MemtoReg,
    input  logic       dRENi,
    input  logic       dWENi,
    input  logic       is_ll,
    input  logic       is_sc,
    input  logic       halt,
    input  word_t      ALUOut,
    input  word_t      store,
    input  word_t      npc,
    mm_stage_if.master dc,
    output logic       mm_stall,
    output logic       wb_valid,
    output logic       wb_RegWEN,
    output regbits_t   wb_rd,
    output word_t      wb_wdat,
    output logic       wb_halt,
    output logic       mm_err
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    mmstate_t  state;
    logic [CW-1:0] cnt;

    regbits_t  h_rd;
    logic      h_regwen;
    memtoreg_t h_mtr;
    word_t     h_alu;
    word_t     h_store;
    word_t     h_npc;
    logic      h_ll;
    logic      h_sc;
    logic      h_ren;
    logic      h_wen;
    logic      wb_regwen_q;

    logic idle;
    logic acc;
    logic hit;
    logic link_match;
    logic sc_fail;
    logic mem_op;

    assign idle    = (state == IDLE);
    assign acc     = (state == ACCESS);
    assign hit     = acc & dc.dhit;
    assign sc_fail = is_sc & ~link_match;
    assign mem_op  = (dRENi | dWENi) & ~sc_fail;

    mm_stage_link_reg u_link (
        .CLK        (CLK),
        .RST        (RST),
        .set        (hit & h_ll),
        .clr        ((idle & sc_fail) | (hit & h_sc)),
        .st         (hit & h_wen & ~h_sc),
        .snoop      (dc.ccinv),
        .addr       (h_alu),
        .snoop_addr (dc.ccsnoopaddr),
        .cmp_addr   (ALUOut),
        .match      (link_match)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            h_rd        <= '0;
            h_regwen    <= 1'b0;
            h_mtr       <= MTR_ALU;
            h_alu       <= '0;
            h_store     <= '0;
            h_npc       <= '0;
            h_ll        <= 1'b0;
            h_sc        <= 1'b0;
            h_ren       <= 1'b0;
            h_wen       <= 1'b0;
            wb_valid    <= 1'b0;
            wb_regwen_q <= 1'b0;
            wb_rd       <= '0;
            wb_wdat     <= '0;
            wb_halt     <= 1'b0;
            mm_err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (halt)
                        wb_halt <= 1'b1;
                    if (mem_op) begin
                        h_rd     <= rd;
                        h_regwen <= RegWEN;
                        h_mtr    <= memtoreg_t'(MemtoReg);
                        h_alu    <= ALUOut;
                        h_store  <= store;
                        h_npc    <= npc;
                        h_ll     <= is_ll;
                        h_sc     <= is_sc;
                        h_ren    <= dRENi;
                        h_wen    <= dWENi;
                        wb_valid <= 1'b0;
                        cnt      <= '0;
                        state    <= ACCESS;
                    end else begin
                        wb_valid    <= 1'b1;
                        wb_rd       <= rd;
                        wb_regwen_q <= RegWEN;
                        wb_wdat     <= sc_fail ? '0 :
                            wsel(memtoreg_t'(MemtoReg), ALUOut, npc);
                    end
                end
                ACCESS: begin
                    if (dc.dhit) begin
                        wb_valid    <= 1'b1;
                        wb_rd       <= h_rd;
                        wb_regwen_q <= h_regwen;
                        wb_wdat     <= h_ren ? dc.dmemload :
                                       h_sc  ? 32'd1 :
                                       wsel(h_mtr, h_alu, h_npc);
                        cnt         <= '0;
                        state       <= DONE;
                    end else if (cnt == CW'(MAX_WAIT - 1)) begin
                        mm_err   <= 1'b1;
                        wb_valid <= 1'b0;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Upstream still presents the finished op here.
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dc.dmemREN   = acc & h_ren;
    assign dc.dmemWEN   = acc & h_wen;
    assign dc.dmemaddr  = acc ? h_alu : '0;
    assign dc.dmemstore = acc ? h_store : '0;

    assign mm_stall  = acc | (idle & mem_op);
    assign wb_RegWEN = wb_regwen_q & wb_valid;

endmodule

// File: tb/tb_mm_stage.sv
// Directed self-checking bench for mm_stage.
// Drives EX/MEM fields and the cache bundle, checks stall/WB/cache.
module tb_mm_stage;
    import mm_stage_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    regbits_t   rd;
    logic       RegWEN;
    logic [1:0] MemtoReg;
    logic       dRENi;
    logic       dWENi;
    logic       is_ll;
    logic       is_sc;
    logic       halt;
    word_t      ALUOut;
    word_t      store;
    word_t      npc;
    logic       mm_stall;
    logic       wb_valid;
    logic       wb_RegWEN;
    regbits_t   wb_rd;
    word_t      wb_wdat;
    logic       wb_halt;
    logic       mm_err;

    int n_cmp = 0;
    int n_bad = 0;

    mm_stage_if dif ();

    mm_stage #(.MAX_WAIT(255)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rd        (rd),
        .RegWEN    (RegWEN),
        .MemtoReg  (MemtoReg),
        .dRENi     (dRENi),
        .dWENi     (dWENi),
        .is_ll     (is_ll),
        .is_sc     (is_sc),
        .halt      (halt),
        .ALUOut    (ALUOut),
        .store     (store),
        .npc       (npc),
        .dc        (dif),
        .mm_stall  (mm_stall),
        .wb_valid  (wb_valid),
        .wb_RegWEN (wb_RegWEN),
        .wb_rd     (wb_rd),
        .wb_wdat   (wb_wdat),
        .wb_halt   (wb_halt),
        .mm_err    (mm_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic nop;
        rd = '0; RegWEN = 0; MemtoReg = 2'd0;
        dRENi = 0; dWENi = 0; is_ll = 0; is_sc = 0; halt = 0;
        ALUOut = '0; store = '0; npc = '0;
        dif.dhit = 0; dif.dmemload = '0;
        dif.ccinv = 0; dif.ccsnoopaddr = '0;
    endtask

    task automatic set_ll(input word_t a);
        nop; dRENi = 1; is_ll = 1; ALUOut = a;
        rd = 5'd9; RegWEN = 1; MemtoReg = 2'd1;
    endtask

    task automatic set_sc(input word_t a);
        nop; dWENi = 1; is_sc = 1; ALUOut = a;
        store = 32'hAA; rd = 5'd8; RegWEN = 1;
    endtask

    // Entry edge, `waits` idle ACCESS cycles, then a dhit cycle.
    task automatic run_mem(input int waits);
        tick;
        repeat (waits) tick;
        dif.dhit = 1;
        tick;
        dif.dhit = 0;
    endtask

    task automatic test_reset;
        RST = 1; nop;
        tick; tick;
        n_cmp++; if ({dif.dmemREN, dif.dmemWEN, dif.dmemaddr, dif.dmemstore} !== '0) begin n_bad++; $display("FAIL rst_cache got %b%b %h %h want 0", dif.dmemREN, dif.dmemWEN, dif.dmemaddr, dif.dmemstore); end
        n_cmp++; if ({mm_stall, wb_valid, wb_RegWEN, wb_rd, wb_wdat, wb_halt, mm_err} !== '0) begin n_bad++; $display("FAIL rst_wb got stall=%b v=%b we=%b rd=%0d wd=%h h=%b e=%b want 0", mm_stall, wb_valid, wb_RegWEN, wb_rd, wb_wdat, wb_halt, mm_err); end
        RST = 0;
    endtask

    task automatic test_alu;
        nop; rd = 5'd5; RegWEN = 1; ALUOut = 32'h1234; MemtoReg = 2'd0;
        #1;
        n_cmp++; if (mm_stall !== 1'b0) begin n_bad++; $display("FAIL alu_stall got %b want 0", mm_stall); end
        tick;
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL alu_valid got %b want 1", wb_valid); end
        n_cmp++; if (wb_rd !== 5'd5) begin n_bad++; $display("FAIL alu_rd got %0d want 5", wb_rd); end
        n_cmp++; if (wb_wdat !== 32'h1234) begin n_bad++; $display("FAIL alu_wdat got %h want 00001234", wb_wdat); end
        n_cmp++; if (wb_RegWEN !== 1'b1) begin n_bad++; $display("FAIL alu_we got %b want 1", wb_RegWEN); end
        MemtoReg = 2'd2; npc = 32'h44; rd = 5'd6;
        tick;
        n_cmp++; if (wb_wdat !== 32'h44) begin n_bad++; $display("FAIL npc_wdat got %h want 00000044", wb_wdat); end
        n_cmp++; if (wb_rd !== 5'd6) begin n_bad++; $display("FAIL npc_rd got %0d want 6", wb_rd); end
        n_cmp++; if (mm_stall !== 1'b0) begin n_bad++; $display("FAIL npc_stall got %b want 0", mm_stall); end
        nop;
    endtask

    task automatic test_load;
        nop; dRENi = 1; ALUOut = 32'h100; rd = 5'd7; RegWEN = 1; MemtoReg = 2'd1;
        #1;
        n_cmp++; if (mm_stall !== 1'b1) begin n_bad++; $display("FAIL ld_entry_stall got %b want 1", mm_stall); end
        n_cmp++; if (dif.dmemREN !== 1'b0) begin n_bad++; $display("FAIL ld_idle_ren got %b want 0", dif.dmemREN); end
        tick;
        n_cmp++; if (wb_RegWEN !== 1'b0) begin n_bad++; $display("FAIL ld_we_gated got %b want 0", wb_RegWEN); end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin dif.dhit = 1; dif.dmemload = 32'hDEADBEEF; end
            n_cmp++; if (dif.dmemaddr !== 32'h100) begin n_bad++; $display("FAIL ld_addr[%0d] got %h want 00000100", i, dif.dmemaddr); end
            n_cmp++; if (dif.dmemREN !== 1'b1) begin n_bad++; $display("FAIL ld_ren[%0d] got %b want 1", i, dif.dmemREN); end
            n_cmp++; if (mm_stall !== 1'b1) begin n_bad++; $display("FAIL ld_stall[%0d] got %b want 1", i, mm_stall); end
            n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL ld_valid[%0d] got %b want 0", i, wb_valid); end
            tick;
        end
        dif.dhit = 0; dif.dmemload = '0;
        n_cmp++; if (dif.dmemREN !== 1'b0) begin n_bad++; $display("FAIL ld_done_ren got %b want 0", dif.dmemREN); end
        n_cmp++; if (mm_stall !== 1'b0) begin n_bad++; $display("FAIL ld_done_stall got %b want 0", mm_stall); end
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL ld_done_valid got %b want 1", wb_valid); end
        n_cmp++; if (wb_wdat !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_wdat got %h want deadbeef", wb_wdat); end
        n_cmp++; if (wb_rd !== 5'd7) begin n_bad++; $display("FAIL ld_rd got %0d want 7", wb_rd); end
        tick;
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL ld_after_valid got %b want 0", wb_valid); end
        nop;
    endtask

    task automatic test_llsc;
        set_ll(32'h200); dif.dmemload = 32'h77;
        run_mem(1);
        n_cmp++; if (wb_wdat !== 32'h77) begin n_bad++; $display("FAIL ll_wdat got %h want 00000077", wb_wdat); end
        tick;
        set_sc(32'h200);
        #1;
        n_cmp++; if (mm_stall !== 1'b1) begin n_bad++; $display("FAIL sc_ok_stall got %b want 1", mm_stall); end
        tick;
        n_cmp++; if (dif.dmemWEN !== 1'b1) begin n_bad++; $display("FAIL sc_wen got %b want 1", dif.dmemWEN); end
        n_cmp++; if (dif.dmemstore !== 32'hAA) begin n_bad++; $display("FAIL sc_store got %h want 000000aa", dif.dmemstore); end
        n_cmp++; if (dif.dmemREN !== 1'b0) begin n_bad++; $display("FAIL sc_ren got %b want 0", dif.dmemREN); end
        dif.dhit = 1;
        tick;
        dif.dhit = 0;
        n_cmp++; if (wb_wdat !== 32'd1) begin n_bad++; $display("FAIL sc_ok_wdat got %h want 00000001", wb_wdat); end
        n_cmp++; if (wb_rd !== 5'd8) begin n_bad++; $display("FAIL sc_ok_rd got %0d want 8", wb_rd); end
        tick;
        n_cmp++; if (mm_stall !== 1'b0) begin n_bad++; $display("FAIL sc_rep_stall got %b want 0", mm_stall); end
        n_cmp++; if (dif.dmemWEN !== 1'b0) begin n_bad++; $display("FAIL sc_rep_wen got %b want 0", dif.dmemWEN); end
        tick;
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL sc_rep_valid got %b want 1", wb_valid); end
        n_cmp++; if (wb_wdat !== 32'd0) begin n_bad++; $display("FAIL sc_rep_wdat got %h want 0", wb_wdat); end
        n_cmp++; if (dif.dmemWEN !== 1'b0) begin n_bad++; $display("FAIL sc_rep_wen2 got %b want 0", dif.dmemWEN); end
        nop;
    endtask

    task automatic test_snoop;
        set_ll(32'h200); run_mem(0); tick;
        nop; dif.ccinv = 1; dif.ccsnoopaddr = 32'h200;
        tick;
        set_sc(32'h200);
        #1;
        n_cmp++; if (mm_stall !== 1'b0) begin n_bad++; $display("FAIL snp_sc_stall got %b want 0", mm_stall); end
        tick;
        n_cmp++; if (wb_wdat !== 32'd0) begin n_bad++; $display("FAIL snp_sc_wdat got %h want 0", wb_wdat); end
        set_ll(32'h200);
        tick;
        dif.dhit = 1; dif.ccinv = 1; dif.ccsnoopaddr = 32'h200;
        tick;
        dif.dhit = 0; dif.ccinv = 0;
        tick;
        set_sc(32'h200);
        #1;
        n_cmp++; if (mm_stall !== 1'b0) begin n_bad++; $display("FAIL snp_same_stall got %b want 0", mm_stall); end
        tick;
        n_cmp++; if (wb_wdat !== 32'd0) begin n_bad++; $display("FAIL snp_same_wdat got %h want 0", wb_wdat); end
        set_ll(32'h200); run_mem(0); tick;
        nop; dif.ccinv = 1; dif.ccsnoopaddr = 32'h204;
        tick;
        set_sc(32'h200);
        #1;
        n_cmp++; if (mm_stall !== 1'b1) begin n_bad++; $display("FAIL snp_other_stall got %b want 1", mm_stall); end
        run_mem(0);
        n_cmp++; if (wb_wdat !== 32'd1) begin n_bad++; $display("FAIL snp_other_wdat got %h want 00000001", wb_wdat); end
        tick;
        nop;
    endtask

    task automatic test_store_inv;
        set_ll(32'h300); run_mem(0); tick;
        nop; dWENi = 1; ALUOut = 32'h300; store = 32'h5;
        run_mem(0);
        n_cmp++; if (wb_wdat !== 32'h300) begin n_bad++; $display("FAIL st_wdat got %h want 00000300", wb_wdat); end
        n_cmp++; if (wb_RegWEN !== 1'b0) begin n_bad++; $display("FAIL st_we got %b want 0", wb_RegWEN); end
        tick;
        set_sc(32'h300);
        #1;
        n_cmp++; if (mm_stall !== 1'b0) begin n_bad++; $display("FAIL st_sc_stall got %b want 0", mm_stall); end
        tick;
        n_cmp++; if (wb_wdat !== 32'd0) begin n_bad++; $display("FAIL st_sc_wdat got %h want 0", wb_wdat); end
        set_ll(32'h300); run_mem(0); tick;
        set_sc(32'h304);
        #1;
        n_cmp++; if (mm_stall !== 1'b0) begin n_bad++; $display("FAIL sc_addr_stall got %b want 0", mm_stall); end
        nop;
        tick;
    endtask

    task automatic test_halt;
        nop; halt = 1; RegWEN = 1; rd = 5'd3; ALUOut = 32'h55;
        tick;
        n_cmp++; if (wb_halt !== 1'b1) begin n_bad++; $display("FAIL halt_set got %b want 1", wb_halt); end
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL halt_valid got %b want 1", wb_valid); end
        n_cmp++; if (wb_wdat !== 32'h55) begin n_bad++; $display("FAIL halt_wdat got %h want 00000055", wb_wdat); end
        nop;
        tick; tick;
        n_cmp++; if (wb_halt !== 1'b1) begin n_bad++; $display("FAIL halt_sticky got %b want 1", wb_halt); end
    endtask

    task automatic test_timeout;
        nop; dRENi = 1; ALUOut = 32'h400; rd = 5'd2; RegWEN = 1; MemtoReg = 2'd1;
        tick;
        repeat (254) tick;
        n_cmp++; if (mm_err !== 1'b0) begin n_bad++; $display("FAIL to_early_err got %b want 0", mm_err); end
        n_cmp++; if (dif.dmemREN !== 1'b1) begin n_bad++; $display("FAIL to_early_ren got %b want 1", dif.dmemREN); end
        tick;
        n_cmp++; if (mm_err !== 1'b1) begin n_bad++; $display("FAIL to_err got %b want 1", mm_err); end
        n_cmp++; if (dif.dmemREN !== 1'b0) begin n_bad++; $display("FAIL to_ren got %b want 0", dif.dmemREN); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL to_valid got %b want 0", wb_valid); end
        nop;
        #1;
        n_cmp++; if (mm_stall !== 1'b0) begin n_bad++; $display("FAIL to_idle_stall got %b want 0", mm_stall); end
        tick; tick;
        n_cmp++; if (mm_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky got %b want 1", mm_err); end
    endtask

    task automatic test_rst_mid;
        nop; dRENi = 1; ALUOut = 32'h500; rd = 5'd1; RegWEN = 1; MemtoReg = 2'd1;
        tick; tick;
        n_cmp++; if (dif.dmemREN !== 1'b1) begin n_bad++; $display("FAIL rm_ren_pre got %b want 1", dif.dmemREN); end
        #2;
        RST = 1; nop;
        #1;
        n_cmp++; if (dif.dmemREN !== 1'b0) begin n_bad++; $display("FAIL rm_ren got %b want 0", dif.dmemREN); end
        n_cmp++; if ({dif.dmemWEN, dif.dmemaddr, mm_stall, wb_valid, wb_RegWEN, wb_rd, wb_wdat, wb_halt, mm_err} !== '0) begin n_bad++; $display("FAIL rm_outs got a=%h s=%b v=%b wd=%h h=%b e=%b want 0", dif.dmemaddr, mm_stall, wb_valid, wb_wdat, wb_halt, mm_err); end
        tick;
        RST = 0;
        rd = 5'd4; RegWEN = 1; ALUOut = 32'hABC;
        tick;
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL rm_alu_valid got %b want 1", wb_valid); end
        n_cmp++; if (wb_wdat !== 32'hABC) begin n_bad++; $display("FAIL rm_alu_wdat got %h want 00000abc", wb_wdat); end
        n_cmp++; if (wb_rd !== 5'd4) begin n_bad++; $display("FAIL rm_alu_rd got %0d want 4", wb_rd); end
        n_cmp++; if (mm_stall !== 1'b0) begin n_bad++; $display("FAIL rm_alu_stall got %b want 0", mm_stall); end
        nop;
    endtask

    initial begin
        test_reset;
        test_alu;
        test_load;
        test_llsc;
        test_snoop;
        test_store_inv;
        test_halt;
        test_timeout;
        test_rst_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
